// File: rtl/muldiv_sequencer_if.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer_if
//
// Handshake bundle between the EX-stage control path and the multi-cycle
// RV32M multiply/divide unit.
//
//   start   control -> unit   request, sampled only while the unit is idle
//   Funct3  control -> unit   M-op select, sampled with start
//   SrcA    control -> unit   rs1 operand (multiplicand / dividend)
//   SrcB    control -> unit   rs2 operand (multiplier / divisor)
//   kill    control -> unit   pipeline flush, aborts the operation in flight
//   busy    unit -> control   high in every state except idle
//   stall   unit -> control   (start && idle) || busy, combinational
//   done    unit -> control   one-cycle pulse, result valid in that cycle
//   result  unit -> control   final value, held until the next done
//
// The control path connects through the master modport, the unit through
// the slave modport.
// -----------------------------------------------------------------------------
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       Funct3;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             kill;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, Funct3, SrcA, SrcB, kill,
        input  busy, stall, done, result
    );

    modport slave (
        input  start, Funct3, SrcA, SrcB, kill,
        output busy, stall, done, result
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Multi-cycle RV32M multiply/divide unit sitting beside the single-cycle ALU
// in the EX stage. One result bit is produced per cycle:
//   - multiply: shift-add on a 2*WIDTH product register
//   - divide:   restoring division on a {remainder, quotient} pair
// Both share the same 2*WIDTH register and the same WIDTH-bit operand register
// (multiplicand for multiply, divisor for divide).
//
// FSM: IDLE -> PREP -> CALC (WIDTH cycles) -> FIN -> IDLE
//      PREP jumps straight to FIN for divide-by-zero and signed overflow.
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   reset  synchronous, active-low reset
//   bus    muldiv_sequencer_if slave modport (see interface header)
//
// Latency from the edge that samples start to the cycle done is high:
//   WIDTH+2 cycles normally, 2 cycles on the fast path.
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6     // must satisfy 2**CNT_W > WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    muldiv_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        CALC = 2'd2,
        FIN  = 2'd3
    } state_t;

    // Funct3 encodings
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state;
    logic [2:0]         op;         // latched Funct3
    logic [WIDTH-1:0]   src_a;      // latched SrcA
    logic [WIDTH-1:0]   src_b;      // latched SrcB
    logic [WIDTH-1:0]   opnd;       // multiplicand (mul) or divisor (div) magnitude
    logic [2*WIDTH-1:0] prod;       // mul: product; div: {remainder, quotient}
    logic               neg_res;    // negate the selected result in FIN
    logic [CNT_W-1:0]   cnt;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;

    // ------------------------------------------------------------------
    // Operand conditioning (used in PREP)
    // ------------------------------------------------------------------
    logic             a_signed;
    logic             b_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             neg_res_d;
    logic             div_zero;
    logic             div_ovf;
    logic [WIDTH-1:0] fast_quo;
    logic [WIDTH-1:0] fast_rem;

    // NOTE: every signal written in an always_comb gets a default on the
    // first lines, so no path can leave it unassigned and infer a latch.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        if (op[2]) begin
            // DIV/REM are signed, DIVU/REMU are not
            a_signed = ~op[0];
            b_signed = ~op[0];
        end else begin
            // MUL/MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned
            a_signed = (op[1:0] != 2'b11);
            b_signed = ~op[1];
        end

        a_neg = a_signed & src_a[WIDTH-1];
        b_neg = b_signed & src_b[WIDTH-1];
        a_mag = a_neg ? -src_a : src_a;
        b_mag = b_neg ? -src_b : src_b;

        // Remainder takes the dividend sign; product and quotient the xor.
        neg_res_d = (op[2] && op[1]) ? a_neg : (a_neg ^ b_neg);

        div_zero = (src_b == '0);
        div_ovf  = ~op[0] && (src_a == MIN_NEG) && (src_b == '1);

        // Fast-path answers, placed where FIN will pick them up unmodified.
        fast_quo = div_zero ? '1    : src_a;
        fast_rem = div_zero ? src_a : '0;
    end

    // ------------------------------------------------------------------
    // One iteration of each datapath (used in CALC)
    // ------------------------------------------------------------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;   // {rem, quo msb}: the trial remainder
    logic               div_fits;
    logic [WIDTH-1:0]   div_sub;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        // Shift-add: conditionally add to the upper half, keep the carry,
        // then shift the whole product right one place.
        mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, prod[WIDTH-1:1]};

        // Restoring divide. The shifted remainder is below 2*divisor, so
        // when it fits the difference is below divisor and the low WIDTH
        // bits of a modular subtract are exact.
        div_shift = prod[2*WIDTH-1:WIDTH-1];
        div_fits  = (div_shift >= {1'b0, opnd});
        div_sub   = div_shift[WIDTH-1:0] - opnd;
        if (div_fits) begin
            div_next = {div_sub, prod[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {div_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
        end
    end

    // ------------------------------------------------------------------
    // Sign correction and output select (used in FIN)
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] mul_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fin_value;

    always_comb begin
        mul_fix = neg_res ? -prod : prod;
        quo_fix = neg_res ? -prod[WIDTH-1:0]       : prod[WIDTH-1:0];
        rem_fix = neg_res ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];

        unique case (op)
            OP_MUL:                     fin_value = mul_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_value = mul_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:            fin_value = quo_fix;
            default:                    fin_value = rem_fix;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM and registers
    // ------------------------------------------------------------------
    // NOTE: sequential state is only ever assigned with <= so every flop
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the datapath registers are cleared as well, not just the
            // control state, so a reset mid-operation leaves nothing stale.
            state    <= IDLE;
            op       <= '0;
            src_a    <= '0;
            src_b    <= '0;
            opnd     <= '0;
            prod     <= '0;
            neg_res  <= 1'b0;
            cnt      <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (bus.start && !bus.kill) begin
                        op    <= bus.Funct3;
                        src_a <= bus.SrcA;
                        src_b <= bus.SrcB;
                        state <= PREP;
                    end
                end

                PREP: begin
                    if (bus.kill) begin
                        state <= IDLE;
                    end else if (op[2] && (div_zero || div_ovf)) begin
                        prod    <= {fast_rem, fast_quo};
                        neg_res <= 1'b0;
                        state   <= FIN;
                    end else begin
                        cnt     <= '0;
                        neg_res <= neg_res_d;
                        if (op[2]) begin
                            opnd <= b_mag;
                            prod <= {{WIDTH{1'b0}}, a_mag};
                        end else begin
                            opnd <= a_mag;
                            prod <= {{WIDTH{1'b0}}, b_mag};
                        end
                        state <= CALC;
                    end
                end

                CALC: begin
                    if (bus.kill) begin
                        state <= IDLE;
                    end else begin
                        prod <= op[2] ? div_next : mul_next;
                        cnt  <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH-1)) begin
                            state <= FIN;
                        end
                    end
                end

                FIN: begin
                    // A flush landing here still wins: no done, result kept.
                    state <= IDLE;
                    if (!bus.kill) begin
                        done_q   <= 1'b1;
                        result_q <= fin_value;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic busy;

    assign busy       = (state != IDLE);
    assign bus.busy   = busy;
    assign bus.stall  = (bus.start && (state == IDLE)) || busy;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Self-checking bench for muldiv_sequencer. Expected results come from a
// behavioural model using plain 64-bit integer arithmetic, and expected
// latencies from the fast-path rules. Directed cases, kill/reset scenarios,
// back-to-back starts and a randomized run.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

    localparam int WIDTH = 32;
    localparam int NORM_LAT = WIDTH + 2;
    localparam int FAST_LAT = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;

    muldiv_sequencer_if #(.WIDTH(WIDTH)) bus();

    muldiv_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_result = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, pu;
        int              ia, ib, q;
        logic [31:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        ia = $signed(a);
        ib = $signed(b);
        r  = '0;
        case (f3)
            3'b000: begin p = sa * sb;           r = p[31:0];   end
            3'b001: begin p = sa * sb;           r = p[63:32];  end
            3'b010: begin p = sa * longint'(ub); r = p[63:32];  end
            3'b011: begin pu = ua * ub;          r = pu[63:32]; end
            3'b100: begin
                if (b == 0) r = '1;
                else if (a == 32'h8000_0000 && b == '1) r = a;
                else begin q = ia / ib; r = q; end
            end
            3'b101: r = (b == 0) ? '1 : a / b;
            3'b110: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == '1) r = '0;
                else begin q = ia % ib; r = q; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == '1)))
            return FAST_LAT;
        return NORM_LAT;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return '1;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // One operation. Called and returns #1 after a rising edge. start is
    // held high while stalled (operands scrambled, as they must be ignored)
    // and dropped in the done cycle unless hold_start asks for a
    // back-to-back request.
    // ------------------------------------------------------------------
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat,
                          input bit hold_start);
        int lat;
        bit stall_ok;
        bus.start  = 1'b1;
        bus.kill   = 1'b0;
        bus.Funct3 = f3;
        bus.SrcA   = a;
        bus.SrcB   = b;
        #1;
        check({tag, "_stall_req"}, 32'(bus.stall), 32'd1);
        @(posedge clk); #1;
        bus.Funct3 = 3'($urandom);
        bus.SrcA   = $urandom;
        bus.SrcB   = $urandom;
        lat = 0;
        stall_ok = 1'b1;
        while (bus.done !== 1'b1 && lat < 60) begin
            if (bus.stall !== 1'b1) stall_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, bus.result, exp_r);
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        check({tag, "_stall_held"}, 32'(stall_ok), 32'd1);
        last_result = exp_r;
        if (!hold_start) begin
            bus.start = 1'b0;
            @(posedge clk); #1;
            check({tag, "_done_1cyc"}, 32'(bus.done), 32'd0);
            check({tag, "_res_held"}, bus.result, exp_r);
            check({tag, "_idle_after"}, 32'(bus.busy), 32'd0);
        end
    endtask

    task automatic run_model(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input bit hold_start);
        run_op(tag, f3, a, b, ref_result(f3, a, b), ref_latency(f3, a, b), hold_start);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int ndone;
        bus.start  = 1'b1;   // start during reset must be ignored
        bus.kill   = 1'b0;
        bus.Funct3 = 3'b000;
        bus.SrcA   = 32'd3;
        bus.SrcB   = 32'd4;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   32'(bus.busy), 32'd0);
        check("rst_done",   32'(bus.done), 32'd0);
        check("rst_result", bus.result,    32'd0);
        reset     = 1'b1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("rst_release_idle", 32'(bus.busy), 32'd0);

        // Directed cases with values taken straight from the arithmetic rules
        run_op("mul_7x-3",   3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, NORM_LAT, 0);
        run_op("mulh_min2",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, NORM_LAT, 0);
        run_op("mulhu_min2", 3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, NORM_LAT, 0);
        run_op("mulhsu_m1",  3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, NORM_LAT, 0);
        run_op("div_-7_2",   3'b100, -32'd7,        32'd2,         32'hFFFF_FFFD, NORM_LAT, 0);
        run_op("rem_-7_2",   3'b110, -32'd7,        32'd2,         32'hFFFF_FFFF, NORM_LAT, 0);
        run_op("divu_100_7", 3'b101, 32'd100,       32'd7,         32'd14,        NORM_LAT, 0);
        run_op("remu_100_7", 3'b111, 32'd100,       32'd7,         32'd2,         NORM_LAT, 0);
        run_op("divu_by0",   3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, FAST_LAT, 0);
        run_op("rem_by0",    3'b110, 32'd5,         32'd0,         32'd5,         FAST_LAT, 0);
        run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, FAST_LAT, 0);
        run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         FAST_LAT, 0);

        // Abort in CALC: kill at cycle 10, no done afterwards, result kept
        bus.start = 1'b1; bus.Funct3 = 3'b000; bus.SrcA = 32'd123; bus.SrcB = 32'd456;
        @(posedge clk); #1;
        repeat (10) begin @(posedge clk); #1; end
        bus.kill  = 1'b1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("kill_calc_busy", 32'(bus.busy), 32'd0);
        check("kill_calc_done", 32'(bus.done), 32'd0);
        bus.kill = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) ndone++;
        end
        check("kill_calc_no_done", 32'(ndone), 32'd0);
        check("kill_calc_result",  bus.result, last_result);
        run_op("divu_9_3", 3'b101, 32'd9, 32'd3, 32'd3, NORM_LAT, 0);

        // Kill landing in FIN: done suppressed, result not updated
        bus.start = 1'b1; bus.Funct3 = 3'b011; bus.SrcA = 32'hDEAD_BEEF; bus.SrcB = 32'h1234_5678;
        @(posedge clk); #1;
        repeat (NORM_LAT - 1) begin @(posedge clk); #1; end
        bus.kill  = 1'b1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("kill_fin_done",   32'(bus.done), 32'd0);
        check("kill_fin_busy",   32'(bus.busy), 32'd0);
        check("kill_fin_result", bus.result,    last_result);
        bus.kill = 1'b0;

        // kill together with start in IDLE: not accepted
        bus.start = 1'b1; bus.kill = 1'b1; bus.Funct3 = 3'b101; bus.SrcA = 32'd8; bus.SrcB = 32'd0;
        @(posedge clk); #1;
        check("kill_idle_busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b0; bus.kill = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("kill_idle_no_done", 32'(bus.done), 32'd0);

        // Reset in the middle of a divide
        bus.start = 1'b1; bus.Funct3 = 3'b100; bus.SrcA = 32'd1000; bus.SrcB = -32'd7;
        @(posedge clk); #1;
        repeat (20) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_busy",   32'(bus.busy), 32'd0);
        check("rst_mid_done",   32'(bus.done), 32'd0);
        check("rst_mid_result", bus.result,    32'd0);
        @(posedge clk); #1;
        check("rst_mid_start_ignored", 32'(bus.busy), 32'd0);
        reset     = 1'b1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_release", 32'(bus.busy), 32'd0);
        last_result = '0;

        // Back-to-back requests, start re-asserted in the done cycle
        run_op("b2b_remu", 3'b111, 32'd100,   32'd7,  32'd2,         NORM_LAT, 1);
        run_op("b2b_div",  3'b100, -32'd7,    32'd2,  32'hFFFF_FFFD, NORM_LAT, 1);
        run_op("b2b_fast", 3'b101, 32'd5,     32'd0,  32'hFFFF_FFFF, FAST_LAT, 1);
        run_op("b2b_rem0", 3'b110, 32'd5,     32'd0,  32'd5,         FAST_LAT, 0);

        // Randomized operations against the model
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            run_model($sformatf("rnd%0d_f%0d", i, f3), f3, a, b, ($urandom_range(0, 3) == 0));
        end
        bus.start = 1'b0;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle RV32M multiply/divide unit with its own FSM, placed beside the single-cycle ALU in the EX stage.
- The control path raises `start` when it decodes an M-extension instruction (opcode 0110011, Funct7 = 0000001).
- The unit holds `stall` high until the result is ready, then pulses `done` so the pipeline can write `result` back.
- A shift-add / restoring-divide datapath processes one bit per cycle.

Parameters:
- WIDTH, 32: operand and result width; iteration count per operation.
- CNT_W, 6: width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start  in  1  request; sampled only in IDLE.
- Funct3  in  3  M-op select, sampled with start:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcA  in  WIDTH  rs1 operand (multiplicand/dividend), sampled with start.
- SrcB  in  WIDTH  rs2 operand (multiplier/divisor), sampled with start.
- kill  in  1  pipeline flush; aborts any operation in progress.
- busy  out  1  high in every state except IDLE.
- stall  out  1  `(start && state==IDLE) || busy`; combinational.
- done  out  1  one-cycle pulse; `result` is valid in that cycle.
- result  out  WIDTH  final value; held from the done cycle until the next accepted start.

Behaviour:
- Reset (reset==0 at an edge): state=IDLE, busy=0, done=0, result=0, counter=0, internal registers cleared. Reset overrides start and kill, including in the middle of an operation.
- States: IDLE, PREP, CALC, FIN.
- IDLE:
  - On start=1 and kill=0: latch Funct3, SrcA and SrcB, then go to PREP.
  - start in any other state is ignored. The control path guarantees start stays high while stall is high.
- PREP (1 cycle):
  - Compute operand magnitudes and the result sign.
    - Signed ops: MUL, MULH, DIV, REM.
    - MULHSU: SrcA signed, SrcB unsigned.
  - Quotient sign = signA ^ signB. Remainder sign = signA.
  - Special cases (fast path, go to FIN, skip CALC):
    - Divisor == 0: DIV/DIVU result = all ones; REM/REMU result = SrcA.
    - DIV/REM with SrcA = 100…0 and SrcB = all ones: DIV result = SrcA, REM result = 0.
  - Otherwise: counter=0, go to CALC.
- CALC (exactly WIDTH cycles):
  - Per cycle, multiply: if the multiplier LSB is 1, add the multiplicand to the upper half of the 2*WIDTH product; then shift right 1.
  - Per cycle, divide: shift the {rem, quo} pair left 1, trial-subtract the divisor, restore if negative, set the quotient bit.
  - Counter increments each cycle; go to FIN when counter == WIDTH-1.
- FIN (1 cycle):
  - Apply sign correction (two's-complement negate).
  - Select the output:
    - MUL → low WIDTH bits.
    - MULH/MULHSU/MULHU → high WIDTH bits.
    - DIV/DIVU → quotient.
    - REM/REMU → remainder.
  - Register result, pulse done=1, return to IDLE.
- Latency:
  - Normal: done is high WIDTH+2 cycles after the start-sampling edge (34 for WIDTH=32).
  - Fast path: done is high 2 cycles after that edge.
- Back-to-back: start may be high in the cycle after done. It is accepted immediately because the FSM is already in IDLE.
- kill:
  - In PREP or CALC: next state is IDLE; no done; result keeps its previous value.
  - In FIN: kill has priority; done is suppressed and result is not updated.
  - kill together with start in IDLE: start is not accepted.
- done is never high for two consecutive cycles. busy is low whenever done is high.
- All arithmetic is modulo 2^WIDTH except the internal 2*WIDTH product and the WIDTH+1-bit trial remainder.

Test Plan:
- MUL: SrcA=7, SrcB=-3 (0xFFFFFFFD), Funct3=000 → done at +34 cycles, result=0xFFFFFFEB; stall high from the start cycle through the cycle before done.
- MULH / MULHU: SrcA=SrcB=0x80000000.
  - MULH → 0x40000000.
  - MULHU → 0x40000000.
  - MULHSU with SrcA=0xFFFFFFFF, SrcB=2 → 0xFFFFFFFF.
- DIV/REM signs: DIV -7/2 → 0xFFFFFFFD (-3); REM -7/2 → 0xFFFFFFFF (-1); DIVU 100/7 → 14; REMU 100/7 → 2.
- Fast paths: each of the following gives done at +2 cycles.
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- Abort: start MUL, assert kill at cycle 10 → IDLE next cycle, no done, result unchanged. Then start DIVU 9/3 → result 3 at +34 cycles.
- Reset: drive reset=0 at cycle 20 of a DIV → busy=0, done=0, result=0 next cycle. start during reset is ignored. A back-to-back start in the cycle after done is accepted.
